vx_scoreboard: RTL

VX_scoreboard sits directly downstream of the instruction buffer and upstream of the dispatch/issue stage. It tracks, per warp, which destination registers have a write in flight. It holds back any instruction that reads or writes a register with a pending write (RAW/WAW hazard). It releases the registers when the writeback stage retires the last packet of the producing instruction.

---
 rtl/vx_scoreboard.sv | 138 +++++++++++++
 1 files changed

// File: rtl/vx_scoreboard.sv
// ---------------------------------------------------------------------------
// vx_scoreboard
//
// Tracks, per warp, which destination registers have a write in flight and
// holds back any instruction at the ibuffer head that touches one of them
// (RAW/WAW hazard).
//
// The handshake between ibuffer and issue is a combinational pass-through
// gated by the hazard. The scoreboard stores no instruction data.
//
// A register is released when writeback retires the last (eop) packet of
// its producer. A stall watchdog raises `deadlock` after DEADLOCK_CYCLES
// consecutive stalled cycles.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ibuf_valid        head instruction valid
//   ibuf_wid          warp of head instruction
//   ibuf_wb           head instruction writes rd
//   ibuf_rd           destination register
//   ibuf_used_regs    mask of all registers the instruction touches
//   ibuf_ready        scoreboard accepts the head instruction
//   issue_valid       instruction forwarded to issue
//   issue_ready       issue stage accepts
//   wb_valid          writeback packet valid
//   wb_wid, wb_rd     writeback warp / register
//   wb_eop            last packet of the instruction's writeback
//   warp_busy         bit i set when warp i has any register in use
//   deadlock          stall watchdog fired
// ---------------------------------------------------------------------------
module vx_scoreboard #(
  parameter int CORE_ID         = 0,
  parameter int DEADLOCK_CYCLES = 10000,
  parameter int NUM_WARPS       = 4,
  parameter int NUM_REGS        = 64,
  parameter int NW_BITS         = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int NR_BITS         = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ibuf_valid,
  input  logic [NW_BITS-1:0]   ibuf_wid,
  input  logic                 ibuf_wb,
  input  logic [NR_BITS-1:0]   ibuf_rd,
  input  logic [NUM_REGS-1:0]  ibuf_used_regs,
  output logic                 ibuf_ready,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  input  logic                 wb_valid,
  input  logic [NW_BITS-1:0]   wb_wid,
  input  logic [NR_BITS-1:0]   wb_rd,
  input  logic                 wb_eop,
  output logic [NUM_WARPS-1:0] warp_busy,
  output logic                 deadlock
);

  localparam logic [19:0] DlLimit = 20'(DEADLOCK_CYCLES);

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] inuse_q, inuse_d;
  logic [19:0]                        stallCnt_q, stallCnt_d;
  logic                               deadlock_q, deadlock_d;

  logic hazard;
  logic issueFire;
  logic wbRelease;

  // Hazard lookup and handshake. The hazard depends only on registered
  // state and ibuffer fields, so issue_valid never depends on issue_ready.
  always_comb begin
    hazard      = |(inuse_q[ibuf_wid] & ibuf_used_regs);
    issue_valid = ibuf_valid && !hazard;
    ibuf_ready  = issue_ready && !hazard;
    issueFire   = ibuf_valid && ibuf_ready;
    wbRelease   = wb_valid && wb_eop;
  end

  // Next-state bitmap. The clear is applied first and the set second, so a
  // new producer issuing in the same cycle as the old one's eop keeps the
  // bit. x0 is hardwired zero and never becomes pending.
  always_comb begin
    inuse_d = inuse_q;
    if (wbRelease) begin
      inuse_d[wb_wid][wb_rd] = 1'b0;
    end
    if (issueFire && ibuf_wb && (ibuf_rd != '0)) begin
      inuse_d[ibuf_wid][ibuf_rd] = 1'b1;
    end
  end

  // Watchdog. It counts consecutive cycles in which a valid head is blocked
  // by a hazard, and saturates at the limit. The flag is sticky until
  // something issues, so a drop of ibuf_valid resets the count but not the
  // flag.
  always_comb begin
    stallCnt_d = stallCnt_q;
    deadlock_d = deadlock_q;
    if (!ibuf_valid || issueFire) begin
      stallCnt_d = '0;
    end else if (hazard && (stallCnt_q != DlLimit)) begin
      stallCnt_d = stallCnt_q + 20'd1;
    end
    if (issueFire) begin
      deadlock_d = 1'b0;
    end else if (stallCnt_d == DlLimit) begin
      deadlock_d = 1'b1;
    end
  end

  // State registers. Reset drops every pending write, so later writebacks
  // from pre-reset instructions find nothing to clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      inuse_q    <= '0;
      stallCnt_q <= '0;
      deadlock_q <= 1'b0;
    end else begin
      inuse_q    <= inuse_d;
      stallCnt_q <= stallCnt_d;
      deadlock_q <= deadlock_d;
    end
  end

  // Busy summary per warp, decoded from the registered bitmap.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_busy[w] = |inuse_q[w];
    end
    deadlock = deadlock_q;
  end

  // Releasing a register that has no write pending means writeback and
  // scoreboard disagree about what is in flight.
  releaseOfIdleReg : assert property (
    @(posedge clk) disable iff (reset)
    (wb_valid && wb_eop) |-> inuse_q[wb_wid][wb_rd]
  ) else $error("core %0d: eop writeback to idle register", CORE_ID);

endmodule
